// File: rtl/bus_arbiter_if.sv
// Request/grant bus between CLIENTS requesters and the arbiter, plus the registered output bus.
// The master modport is the client side; the slave modport is the arbiter side.
interface bus_arbiter_if #(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned CLIENTS = 4
);
  localparam int unsigned OwnerW = $clog2(CLIENTS);

  logic [CLIENTS-1:0]            req;
  logic [CLIENTS-1:0]            last;
  logic [CLIENTS-1:0][WIDTH-1:0] messages;
  logic [CLIENTS-1:0]            ready;
  logic [WIDTH-1:0]              message;
  logic                          valid;
  logic [OwnerW-1:0]             owner;
  logic                          locked;

  modport master (
    output req, last, messages,
    input  ready, message, valid, owner, locked
  );

  modport slave (
    input  req, last, messages,
    output ready, message, valid, owner, locked
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with burst locking: a winner keeps the bus until its last beat,
// the MAX_BURST cap, or until it drops req; the accepted beat is registered onto the bus.
module bus_arbiter #(
  parameter int unsigned WIDTH     = 2,
  parameter int unsigned CLIENTS   = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input logic          clock,
  input logic          reset_n,
  bus_arbiter_if.slave bus
);

  localparam int unsigned PtrW = $clog2(CLIENTS);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [PtrW-1:0]    cur_q, cur_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   message_q, message_d;
  logic               valid_q, valid_d;
  logic [PtrW-1:0]    owner_q, owner_d;
  logic [CLIENTS-1:0] ready_c;
  logic               found;
  logic [PtrW-1:0]    win;

  function automatic logic [PtrW-1:0] next_idx(input logic [PtrW-1:0] x);
    if (int'(x) == int'(CLIENTS) - 1) return '0;
    return x + 1'b1;
  endfunction

  // Scan ptr, ptr+1, ... modulo CLIENTS; first requester found wins.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int unsigned k = 0; k < CLIENTS; k++) begin
      int unsigned idx;
      idx = int'(ptr_q) + k;
      if (idx >= CLIENTS) idx = idx - CLIENTS;
      if (!found && bus.req[PtrW'(idx)]) begin
        found = 1'b1;
        win   = PtrW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    message_d = message_q;
    valid_d   = 1'b0;
    owner_d   = owner_q;
    ready_c   = '0;
    if (state_q == StIdle) begin
      if (found) begin
        ready_c[win] = 1'b1;
        message_d    = bus.messages[win];
        owner_d      = win;
        valid_d      = 1'b1;
        cnt_d        = CntW'(1);
        if (bus.last[win] || (MAX_BURST == 1)) begin
          ptr_d = next_idx(win);
        end else begin
          state_d = StBurst;
          cur_d   = win;
        end
      end
    end else begin
      ready_c[cur_q] = bus.req[cur_q];
      if (bus.req[cur_q]) begin
        message_d = bus.messages[cur_q];
        owner_d   = cur_q;
        valid_d   = 1'b1;
        cnt_d     = cnt_q + CntW'(1);
        if (bus.last[cur_q] || (int'(cnt_q) + 1 == int'(MAX_BURST))) begin
          state_d = StIdle;
          ptr_d   = next_idx(cur_q);
        end
      end else begin
        // Holder went away mid-burst: give up the bus without a transfer.
        state_d = StIdle;
        ptr_d   = next_idx(cur_q);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cur_q     <= '0;
      cnt_q     <= '0;
      message_q <= '0;
      valid_q   <= 1'b0;
      owner_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      message_q <= message_d;
      valid_q   <= valid_d;
      owner_q   <= owner_d;
    end
  end

  // ready is combinational, so it must be forced low while reset is held.
  assign bus.ready   = reset_n ? ready_c : '0;
  assign bus.message = message_q;
  assign bus.valid   = valid_q;
  assign bus.owner   = owner_q;
  assign bus.locked  = (state_q == StBurst);

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level reference model.
module tb_bus_arbiter;
  localparam int unsigned WIDTH     = 2;
  localparam int unsigned CLIENTS   = 4;
  localparam int unsigned MAX_BURST = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  bus_arbiter_if #(.WIDTH(WIDTH), .CLIENTS(CLIENTS)) bus_if ();

  bus_arbiter #(
    .WIDTH    (WIDTH),
    .CLIENTS  (CLIENTS),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: who holds the bus, where the next scan starts, beats so far.
  bit               m_burst;
  int               m_ptr, m_cur, m_cnt, m_owner;
  logic [WIDTH-1:0] m_msg;
  bit               m_valid;

  logic [CLIENTS-1:0]            s_ready, s_last;
  logic [CLIENTS-1:0][WIDTH-1:0] s_msgs;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_burst = 0; m_ptr = 0; m_cur = 0; m_cnt = 0;
    m_owner = 0; m_msg = '0; m_valid = 0;
  endtask

  function automatic logic [CLIENTS-1:0] model_ready();
    logic [CLIENTS-1:0] r;
    bit hit;
    r = '0;
    hit = 0;
    if (!reset_n) return r;
    if (m_burst) begin
      r[m_cur] = bus_if.req[m_cur];
    end else begin
      for (int k = 0; k < CLIENTS; k++) begin
        int i;
        i = (m_ptr + k) % CLIENTS;
        if (!hit && bus_if.req[i]) begin
          r[i] = 1'b1;
          hit = 1;
        end
      end
    end
    return r;
  endfunction

  task automatic model_edge();
    int w;
    w = 0;
    for (int i = 0; i < CLIENTS; i++) if (s_ready[i]) w = i;
    if (s_ready != '0) begin
      m_msg = s_msgs[w]; m_owner = w; m_valid = 1;
      if (!m_burst) begin
        m_cnt = 1;
        if (s_last[w] || MAX_BURST == 1) m_ptr = (w + 1) % CLIENTS;
        else begin m_burst = 1; m_cur = w; end
      end else begin
        m_cnt++;
        if (s_last[w] || m_cnt == MAX_BURST) begin
          m_burst = 0; m_ptr = (m_cur + 1) % CLIENTS;
        end
      end
    end else begin
      m_valid = 0;
      if (m_burst) begin m_burst = 0; m_ptr = (m_cur + 1) % CLIENTS; end
    end
  endtask

  task automatic check_outputs();
    check_eq("valid", bus_if.valid, m_valid);
    check_eq("locked", bus_if.locked, m_burst);
    check_eq("owner", bus_if.owner, m_owner);
    check_eq("message", bus_if.message, m_msg);
  endtask

  // Call with inputs already driven, away from the clock edge.
  task automatic step();
    #1;
    s_ready = model_ready();
    s_last  = bus_if.last;
    s_msgs  = bus_if.messages;
    check_eq("ready", bus_if.ready, s_ready);
    @(posedge clock);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic [CLIENTS-1:0] r, input logic [CLIENTS-1:0] l);
    bus_if.req  = r;
    bus_if.last = l;
  endtask

  initial begin
    drive('0, '0);
    for (int i = 0; i < CLIENTS; i++) bus_if.messages[i] = WIDTH'(CLIENTS - 1 - i);
    model_reset();
    #3;
    drive('1, '1);
    #1;
    check_eq("rst_ready", bus_if.ready, 0);
    check_outputs();

    // Fairness: everyone requests single beats; first transfer right after release.
    #8 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("fair_owner", bus_if.owner, k % CLIENTS);
      check_eq("fair_valid", bus_if.valid, 1);
    end

    // Burst: client 2 three beats while client 0 waits.
    drive(4'b0101, 4'b0000);
    for (int b = 0; b < 3; b++) begin
      bus_if.last = (b == 2) ? 4'b0100 : 4'b0000;
      #1;
      check_eq("burst_rdy2", bus_if.ready[2], 1);
      check_eq("burst_rdy0", bus_if.ready[0], 0);
      step();
      check_eq("burst_owner", bus_if.owner, 2);
    end
    drive(4'b0101, 4'b0001);
    step();
    check_eq("after_burst_owner", bus_if.owner, 0);

    // Cap: client 1 never signals last.
    drive(4'b1010, 4'b0000);
    for (int b = 0; b < 4; b++) begin
      step();
      check_eq("cap_owner1", bus_if.owner, 1);
    end
    step();
    check_eq("cap_owner3", bus_if.owner, 3);
    drive(4'b0000, 4'b0000);
    step();

    // Abort: client 3 drops req on beat 2.
    drive(4'b1000, 4'b0000);
    step();
    check_eq("abort_beat1", bus_if.owner, 3);
    drive(4'b0000, 4'b0000);
    #1;
    check_eq("abort_ready", bus_if.ready, 0);
    step();
    check_eq("abort_valid", bus_if.valid, 0);
    check_eq("abort_locked", bus_if.locked, 0);
    drive(4'b1010, 4'b1010);
    step();
    check_eq("abort_next", bus_if.owner, 1);

    // Idle: bus holds the last beat, then a lone client 1 wins after a full scan.
    drive(4'b0000, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("idle_valid", bus_if.valid, 0);
      check_eq("idle_msg", bus_if.message, WIDTH'(CLIENTS - 2));
    end
    drive(4'b0010, 4'b0010);
    step();
    check_eq("idle_owner", bus_if.owner, 1);

    // Reset in the middle of a client 2 burst.
    drive(4'b0100, 4'b0000);
    step();
    step();
    check_eq("pre_rst_locked", bus_if.locked, 1);
    #3 reset_n = 1'b0;
    #1;
    check_eq("rst_valid", bus_if.valid, 0);
    check_eq("rst_locked", bus_if.locked, 0);
    check_eq("rst_ready2", bus_if.ready, 0);
    model_reset();
    drive('1, '1);
    @(negedge clock);
    reset_n = 1'b1;
    step();
    check_eq("rst_first_owner", bus_if.owner, 0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < CLIENTS; i++) begin
        bus_if.req[i]      = ($urandom_range(0, 3) != 0);
        bus_if.last[i]     = ($urandom_range(0, 2) == 0);
        bus_if.messages[i] = WIDTH'($urandom);
      end
      if ($urandom_range(0, 15) == 0) bus_if.req = '0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
